fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined processor. Owns the PC and drives the imem address.
- Captures the imem word into the F/D pipeline latch consumed by decode.
- Handles decode-stage stalls and branch/jump redirects (flush), and keeps fetch/bubble performance counters.
- imem is clocked on the inverted clock, so q_imem for the current address is valid before the next rising edge.

Parameters:
- PC_W, 12, PC and imem address width (imem depth 2^PC_W words).
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and F/D latch this cycle.
- redirect_valid  in  1  taken branch/jump resolved in execute.
- redirect_pc  in  PC_W  target PC for the redirect.
- q_imem  in  32  instruction word from imem at address_imem.
- address_imem  out  PC_W  equals current PC (combinational from PC register).
- fd_insn  out  32  F/D latch instruction.
- fd_pc  out  PC_W  F/D latch PC+1 (link / branch base).
- fd_valid  out  1  F/D latch holds a real instruction (0 = bubble).
- fetch_count  out  CNT_W  instructions delivered to decode.
- bubble_count  out  CNT_W  cycles F/D was loaded with a bubble.

Behaviour:
- Reset (sync, priority over everything):
  - PC <= RESET_PC; fd_insn <= 0 (nop); fd_pc <= 0; fd_valid <= 0; both counters <= 0.
  - Reset asserted mid-stall or mid-redirect discards that operation.
- State:
  - RUN: normal fetch.
  - FLUSH: exactly one cycle after a redirect.
  - From reset, the block enters RUN.
- Priority each edge: reset > redirect_valid > stall > normal advance.
- Normal advance (RUN, no stall, no redirect):
  - PC <= PC+1, modulo 2^PC_W (4095 wraps to 0 silently).
  - fd_insn <= q_imem; fd_pc <= PC+1 (same wrap rule); fd_valid <= 1; fetch_count += 1.
- Stall only:
  - PC, fd_insn, fd_pc, fd_valid and the counters all hold; address_imem is unchanged.
- Redirect (including when stall is simultaneously high):
  - PC <= redirect_pc; fd_insn <= 0; fd_valid <= 0; fd_pc <= 0; bubble_count += 1; state <= FLUSH.
  - The wrong-path instruction is dropped.
- FLUSH, per edge:
  - If redirect_valid: handle as a new redirect and stay in FLUSH.
  - Else if stall: hold everything and stay in FLUSH.
  - Else: normal advance from redirect_pc, and state <= RUN.
- Latency:
  - An instruction at PC appears on fd_insn one edge after PC is presented.
  - Redirect costs one bubble in F/D; the target instruction is in F/D on the second edge after redirect.
- Counters:
  - Saturate at all-ones and never wrap.
  - Increment only on the events listed above.
- address_imem is never X after reset; fd outputs change only on clock edges.

Decomposition:
- Shared package (cpu_pkg):
  - PC_W default, INSN_W = 32, NOP_INSN = 32'h0.
  - State encoding FETCH_RUN / FETCH_FLUSH.
- Sub-module sat_counter (CNT_W, sync reset, increment enable, saturate), instantiated twice.
- PC and F/D registers stay inline.

Test Plan:
- Reset, then release with imem holding word i = 32'h1000_0000+i, no stall for 4 cycles → address_imem 0,1,2,3; fd_insn 32'h1000_0000..0002 with fd_pc 1..3; fetch_count = 3 after the third advance; fd_valid = 1.
- stall high 3 cycles at PC=5 → address_imem stays 5; fd_insn and fd_pc unchanged; counters unchanged; after release, the next edge loads word 5 and fd_pc = 6.
- redirect_valid with redirect_pc = 12'h040 at PC=8 → next edge: fd_valid = 0, fd_insn = 0, address_imem = 0x040, bubble_count = 1; following edge: fd_insn = word 0x040, fd_pc = 0x041.
- redirect_valid and stall high together with redirect_pc = 0x010 → redirect wins: PC = 0x010, bubble loaded; then stall alone in FLUSH holds PC at 0x010.
- PC at 4095, advance → fd_pc = 0, address_imem = 0; reset asserted during the cycle after a redirect → PC = 0, fd_valid = 0, counters = 0, state RUN.
- Counter saturation with CNT_W = 4 in a parameter sweep: 20 advances → fetch_count stays at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, nop encoding and fetch state encoding for the pipeline
package cpu_pkg;
  localparam int PC_W = 12;
  localparam int INSN_W = 32;
  localparam logic [INSN_W-1:0] NOP_INSN = 32'h0;
  typedef enum logic {FETCH_RUN, FETCH_FLUSH} fetch_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter with sync reset (reset) and enable (en) that sticks at all-ones (count)
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clock)
    if (reset) count <= '0;
    else if (en && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns PC/imem address, loads F/D latch, handles stall/redirect, counts fetches and bubbles
module fetch_stage #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic [31:0]      q_imem,
  output logic [PC_W-1:0]  address_imem,
  output logic [31:0]      fd_insn,
  output logic [PC_W-1:0]  fd_pc,
  output logic             fd_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] bubble_count
);
  import cpu_pkg::*;
  fetch_state_t st, st_nx;
  logic [PC_W-1:0] pc, pc_inc, pc_nx;
  logic adv;
  always_comb begin
    pc_inc = pc + PC_W'(1);
    adv = !redirect_valid && !stall;
    pc_nx = redirect_valid ? redirect_pc : stall ? pc : pc_inc;
    st_nx = redirect_valid ? FETCH_FLUSH : stall ? st : FETCH_RUN;
  end
  always_ff @(posedge clock)
    if (reset) begin
      pc <= RESET_PC;
      st <= FETCH_RUN;
      fd_insn <= NOP_INSN;
      fd_pc <= '0;
      fd_valid <= 1'b0;
    end else begin
      pc <= pc_nx;
      st <= st_nx;
      if (redirect_valid) begin
        fd_insn <= NOP_INSN;
        fd_pc <= '0;
        fd_valid <= 1'b0;
      end else if (adv) begin
        fd_insn <= q_imem;
        fd_pc <= pc_inc;
        fd_valid <= 1'b1;
      end
    end
  assign address_imem = pc;
  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clock(clock), .reset(reset), .en(adv), .count(fetch_count)
  );
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clock(clock), .reset(reset), .en(redirect_valid), .count(bubble_count)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random + directed fetch stimulus checked against a behavioural model
module tb_fetch_stage;
  logic clock = 0, reset, stall, redirect_valid;
  logic [11:0] redirect_pc;
  logic [31:0] q_imem, q_imem_s;
  logic [11:0] address_imem, fd_pc, address_imem_s, fd_pc_s;
  logic [31:0] fd_insn, fd_insn_s;
  logic fd_valid, fd_valid_s;
  logic [31:0] fetch_count, bubble_count;
  logic [3:0] fetch_count_s, bubble_count_s;
  int n_checks = 0, n_fail = 0;
  int m_pc, m_fpc, m_fc, m_bc;
  logic [31:0] m_insn;
  logic m_v;

  always #5 clock = ~clock;
  assign q_imem = 32'h1000_0000 + 32'(address_imem);
  assign q_imem_s = 32'h1000_0000 + 32'(address_imem_s);

  fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .q_imem(q_imem), .address_imem(address_imem),
    .fd_insn(fd_insn), .fd_pc(fd_pc), .fd_valid(fd_valid),
    .fetch_count(fetch_count), .bubble_count(bubble_count)
  );
  fetch_stage #(.CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .q_imem(q_imem_s), .address_imem(address_imem_s),
    .fd_insn(fd_insn_s), .fd_pc(fd_pc_s), .fd_valid(fd_valid_s),
    .fetch_count(fetch_count_s), .bubble_count(bubble_count_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit rv, input int rpc);
    reset = r; stall = s; redirect_valid = rv; redirect_pc = 12'(rpc);
    if (r) begin
      m_pc = 0; m_insn = 0; m_fpc = 0; m_v = 0; m_fc = 0; m_bc = 0;
    end else if (rv) begin
      m_pc = rpc; m_insn = 0; m_fpc = 0; m_v = 0; m_bc++;
    end else if (!s) begin
      m_insn = 32'h1000_0000 + m_pc;
      m_fpc = (m_pc + 1) % 4096;
      m_pc = m_fpc; m_v = 1; m_fc++;
    end
    @(posedge clock); #1;
    check("addr", 64'(address_imem), 64'(m_pc));
    check("fd_insn", 64'(fd_insn), 64'(m_insn));
    check("fd_pc", 64'(fd_pc), 64'(m_fpc));
    check("fd_valid", 64'(fd_valid), 64'(m_v));
    check("fetch_count", 64'(fetch_count), 64'(m_fc));
    check("bubble_count", 64'(bubble_count), 64'(m_bc));
    check("addr_s", 64'(address_imem_s), 64'(m_pc));
    check("fd_insn_s", 64'(fd_insn_s), 64'(m_insn));
    check("fetch_count_s", 64'(fetch_count_s), 64'(m_fc > 15 ? 15 : m_fc));
    check("bubble_count_s", 64'(bubble_count_s), 64'(m_bc > 15 ? 15 : m_bc));
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 'h040);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 'h010);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 4094);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 'h123);
    step(1, 1, 1, 'h200);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 18; i++) step(0, i % 3 == 0, 1, i * 7);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 15, int'($urandom_range(0, 4095)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
